// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy squad: type encoding, slot states and
// the per-type stat table (HP / damage / speed).
package enemy_pkg;

    localparam int TYPE_W = 2;

    typedef enum logic [TYPE_W-1:0] {
        T_SCOUT   = 2'd0,
        T_SOLDIER = 2'd1,
        T_RUNNER  = 2'd2,
        T_TANK    = 2'd3
    } enemy_type_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DEPLOY = 2'd1,
        S_ALIVE  = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [7:0] hp;
        logic [7:0] dmg;
        logic [1:0] speed;
    } enemy_stats_t;

    // Stat lookup by enemy type.
    function automatic enemy_stats_t enemy_stats(input logic [TYPE_W-1:0] t);
        enemy_stats_t s;
        case (t)
            T_SCOUT:   s = '{hp: 8'd64,  dmg: 8'd4,  speed: 2'd1};
            T_SOLDIER: s = '{hp: 8'd128, dmg: 8'd8,  speed: 2'd1};
            T_RUNNER:  s = '{hp: 8'd32,  dmg: 8'd2,  speed: 2'd2};
            T_TANK:    s = '{hp: 8'd255, dmg: 8'd16, speed: 2'd1};
            default:   s = '{hp: 8'd64,  dmg: 8'd4,  speed: 2'd1};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/enemy_squad_if.sv
// Bus between the spawn scheduler / battle logic (master) and the enemy
// squad (slave): spawn handshake, move tick, player strikes and results.
interface enemy_squad_if #(
    parameter int N_SLOTS = 4,
    parameter int POS_W   = 9,
    parameter int DMG_W   = 8
);
    import enemy_pkg::*;

    logic                 spawn_valid;
    logic [TYPE_W-1:0]    spawn_type;
    logic                 spawn_ready;
    logic                 move_tick;
    logic [POS_W-1:0]     unit_front;
    logic                 damage_valid;
    logic [DMG_W-1:0]     damage_in;
    logic [POS_W-1:0]     enemy_front;
    logic                 attack_valid;
    logic [DMG_W-1:0]     damage_out;
    logic                 kill_pulse;
    logic [TYPE_W-1:0]    kill_type;
    logic [N_SLOTS-1:0]   alive_mask;

    modport master (
        output spawn_valid, spawn_type, move_tick, unit_front, damage_valid, damage_in,
        input  spawn_ready, enemy_front, attack_valid, damage_out, kill_pulse, kill_type,
               alive_mask
    );

    modport slave (
        input  spawn_valid, spawn_type, move_tick, unit_front, damage_valid, damage_in,
        output spawn_ready, enemy_front, attack_valid, damage_out, kill_pulse, kill_type,
               alive_mask
    );

endinterface

// File: rtl/enemy_slot.sv
// One enemy slot: IDLE -> DEPLOY -> ALIVE -> IDLE lifecycle, position march
// with clamp at the player front, health and attack contribution.
// Optional feature macro: ENEMY_REGEN_EN (slow health regeneration on ticks).
module enemy_slot
    import enemy_pkg::*;
#(
    parameter int POS_W         = 9,
    parameter int HP_W          = 8,
    parameter int DMG_W         = 8,
    parameter int DEPLOY_CYCLES = 3,
    parameter int REGEN_PERIOD  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spawn_en,
    input  logic [TYPE_W-1:0] spawn_type,
    input  logic              move_tick,
    input  logic [POS_W-1:0]  unit_front,
    input  logic              hit_en,
    input  logic [DMG_W-1:0]  damage_in,
    output logic              alive,
    output logic              idle,
    output logic [POS_W-1:0]  pos,
    output logic [TYPE_W-1:0] etype,
    output logic              alive_nxt,
    output logic              idle_nxt,
    output logic [POS_W-1:0]  pos_nxt,
    output logic              attack,
    output logic [DMG_W-1:0]  attack_dmg,
    output logic              killed
);

    localparam int CNT_W = (DEPLOY_CYCLES > 1) ? $clog2(DEPLOY_CYCLES) : 1;
    localparam int EXT_W = (HP_W > DMG_W) ? HP_W : DMG_W;

    slot_state_e        state_r, state_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [POS_W-1:0]   pos_r, pos_n;
    logic [HP_W-1:0]    hp_r, hp_n;
    logic [TYPE_W-1:0]  type_r, type_n;
    logic [DMG_W-1:0]   dmg_r, dmg_n;
    logic [1:0]         spd_r, spd_n;

    enemy_stats_t       spawn_st_s;
    logic [POS_W-1:0]   spd_ext_s;
    logic [POS_W:0]     reach_s;
    logic [POS_W-1:0]   step_pos_s;
    logic               in_range_s;
    logic [HP_W-1:0]    hp_base_s;
    logic [HP_W-1:0]    hp_hit_s;
    logic [EXT_W-1:0]   hp_ext_s;
    logic [EXT_W-1:0]   dmg_ext_s;

`ifdef ENEMY_REGEN_EN
    localparam int RG_W = $clog2(REGEN_PERIOD + 1);
    logic [RG_W-1:0]    regen_r, regen_n;
    logic [HP_W-1:0]    max_hp_r, max_hp_n;
    logic               regen_due_s;
`endif

    // March step / attack decision and post-strike health, from start-of-cycle state.
    always_comb begin
        spawn_st_s = enemy_stats(spawn_type);
        spd_ext_s  = {{(POS_W-2){1'b0}}, spd_r};
        reach_s    = {1'b0, unit_front} + {1'b0, spd_ext_s};
        if ({1'b0, pos_r} >= reach_s) begin
            step_pos_s = pos_r - spd_ext_s;
            in_range_s = 1'b0;
        end else if (pos_r > unit_front) begin
            step_pos_s = unit_front;
            in_range_s = 1'b0;
        end else begin
            step_pos_s = pos_r;
            in_range_s = 1'b1;
        end
`ifdef ENEMY_REGEN_EN
        regen_due_s = (state_r == S_ALIVE) && move_tick &&
                      (regen_r == RG_W'(REGEN_PERIOD - 1));
        if (regen_due_s && (hp_r < max_hp_r)) begin
            hp_base_s = hp_r + {{(HP_W-1){1'b0}}, 1'b1};
        end else begin
            hp_base_s = hp_r;
        end
`else
        hp_base_s = hp_r;
`endif
        hp_ext_s  = EXT_W'(hp_base_s);
        dmg_ext_s = EXT_W'(damage_in);
        if (hp_ext_s > dmg_ext_s) begin
            hp_hit_s = HP_W'(hp_ext_s - dmg_ext_s);
        end else begin
            hp_hit_s = {HP_W{1'b0}};
        end
    end

    // Slot lifecycle next-state: spawn load, deploy countdown, move/attack, death.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        pos_n      = pos_r;
        hp_n       = hp_r;
        type_n     = type_r;
        dmg_n      = dmg_r;
        spd_n      = spd_r;
        attack     = 1'b0;
        killed     = 1'b0;
`ifdef ENEMY_REGEN_EN
        regen_n    = regen_r;
        max_hp_n   = max_hp_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (spawn_en) begin
                    state_n = S_DEPLOY;
                    cnt_n   = CNT_W'(DEPLOY_CYCLES - 1);
                    pos_n   = {POS_W{1'b1}};
                    hp_n    = HP_W'(spawn_st_s.hp);
                    type_n  = spawn_type;
                    dmg_n   = DMG_W'(spawn_st_s.dmg);
                    spd_n   = spawn_st_s.speed;
`ifdef ENEMY_REGEN_EN
                    regen_n  = {RG_W{1'b0}};
                    max_hp_n = HP_W'(spawn_st_s.hp);
`endif
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_DEPLOY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_n = S_ALIVE;
                end else begin
                    cnt_n = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_ALIVE: begin
`ifdef ENEMY_REGEN_EN
                if (move_tick) begin
                    regen_n = regen_due_s ? {RG_W{1'b0}} : regen_r + {{(RG_W-1){1'b0}}, 1'b1};
                end else begin
                    regen_n = regen_r;
                end
`endif
                hp_n = hit_en ? hp_hit_s : hp_base_s;
                if (hit_en && (hp_hit_s == {HP_W{1'b0}})) begin
                    state_n = S_IDLE;
                    killed  = 1'b1;
                end else if (move_tick) begin
                    pos_n  = step_pos_s;
                    attack = in_range_s;
                end else begin
                    state_n = S_ALIVE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        attack_dmg = attack ? dmg_r : {DMG_W{1'b0}};
    end

    // Slot state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            pos_r    <= {POS_W{1'b0}};
            hp_r     <= {HP_W{1'b0}};
            type_r   <= {TYPE_W{1'b0}};
            dmg_r    <= {DMG_W{1'b0}};
            spd_r    <= 2'd0;
`ifdef ENEMY_REGEN_EN
            regen_r  <= {RG_W{1'b0}};
            max_hp_r <= {HP_W{1'b0}};
`endif
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            pos_r    <= pos_n;
            hp_r     <= hp_n;
            type_r   <= type_n;
            dmg_r    <= dmg_n;
            spd_r    <= spd_n;
`ifdef ENEMY_REGEN_EN
            regen_r  <= regen_n;
            max_hp_r <= max_hp_n;
`endif
        end
    end

    assign alive     = (state_r == S_ALIVE);
    assign idle      = (state_r == S_IDLE);
    assign pos       = pos_r;
    assign etype     = type_r;
    assign alive_nxt = (state_n == S_ALIVE);
    assign idle_nxt  = (state_n == S_IDLE);
    assign pos_nxt   = pos_n;

endmodule

// File: rtl/enemy_squad.sv
// Multi-slot enemy manager for the battlefield lane. Picks the spawn slot,
// routes player strikes to the frontmost enemy, sums attack damage with
// saturation and registers all results.
// Optional feature macro: ENEMY_REGEN_EN (handled inside enemy_slot).
module enemy_squad
    import enemy_pkg::*;
#(
    parameter int N_SLOTS       = 4,
    parameter int POS_W         = 9,
    parameter int HP_W          = 8,
    parameter int DMG_W         = 8,
    parameter int DEPLOY_CYCLES = 3,
    parameter int REGEN_PERIOD  = 8
) (
    input  logic          clk,
    input  logic          reset,
    enemy_squad_if.slave  bus
);

    localparam int SUM_W = DMG_W + 5;

    logic [N_SLOTS-1:0] idle_s, alive_s, idle_nxt_s, alive_nxt_s;
    logic [N_SLOTS-1:0] spawn_sel_s, spawn_en_s, tgt_oh_s, hit_en_s, attack_s, killed_s;
    logic [POS_W-1:0]   pos_s     [N_SLOTS];
    logic [POS_W-1:0]   pos_nxt_s [N_SLOTS];
    logic [TYPE_W-1:0]  type_s    [N_SLOTS];
    logic [DMG_W-1:0]   atk_dmg_s [N_SLOTS];
    logic               spawn_accept_s;
    logic [SUM_W-1:0]   dmg_sum_s;
    logic [DMG_W-1:0]   dmg_sat_s;
    logic [TYPE_W-1:0]  kill_type_s;
    logic [POS_W-1:0]   front_s;

    logic               spawn_ready_r;
    logic [POS_W-1:0]   enemy_front_r;
    logic               attack_valid_r;
    logic [DMG_W-1:0]   damage_out_r;
    logic               kill_pulse_r;
    logic [TYPE_W-1:0]  kill_type_r;
    logic [N_SLOTS-1:0] alive_mask_r;

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        enemy_slot #(
            .POS_W        (POS_W),
            .HP_W         (HP_W),
            .DMG_W        (DMG_W),
            .DEPLOY_CYCLES(DEPLOY_CYCLES),
            .REGEN_PERIOD (REGEN_PERIOD)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .spawn_en   (spawn_en_s[i]),
            .spawn_type (bus.spawn_type),
            .move_tick  (bus.move_tick),
            .unit_front (bus.unit_front),
            .hit_en     (hit_en_s[i]),
            .damage_in  (bus.damage_in),
            .alive      (alive_s[i]),
            .idle       (idle_s[i]),
            .pos        (pos_s[i]),
            .etype      (type_s[i]),
            .alive_nxt  (alive_nxt_s[i]),
            .idle_nxt   (idle_nxt_s[i]),
            .pos_nxt    (pos_nxt_s[i]),
            .attack     (attack_s[i]),
            .attack_dmg (atk_dmg_s[i]),
            .killed     (killed_s[i])
        );
    end

    // Lowest-index IDLE slot receives an accepted spawn.
    always_comb begin
        logic taken;
        taken       = 1'b0;
        spawn_sel_s = {N_SLOTS{1'b0}};
        for (int i = 0; i < N_SLOTS; i++) begin
            spawn_sel_s[i] = idle_s[i] & ~taken;
            taken          = taken | idle_s[i];
        end
        spawn_accept_s = bus.spawn_valid & spawn_ready_r;
        spawn_en_s     = spawn_sel_s & {N_SLOTS{spawn_accept_s}};
    end

    // Strike target: ALIVE slot with the lowest position, ties to lowest index.
    always_comb begin
        logic             found;
        logic [POS_W-1:0] best;
        found    = 1'b0;
        best     = {POS_W{1'b1}};
        tgt_oh_s = {N_SLOTS{1'b0}};
        for (int i = 0; i < N_SLOTS; i++) begin
            if (alive_s[i] && (!found || (pos_s[i] < best))) begin
                tgt_oh_s    = {N_SLOTS{1'b0}};
                tgt_oh_s[i] = 1'b1;
                found       = 1'b1;
                best        = pos_s[i];
            end else begin
                found = found;
            end
        end
        hit_en_s = tgt_oh_s & {N_SLOTS{bus.damage_valid}};
    end

    // Saturating attack sum, killed-slot type and post-edge front position.
    always_comb begin
        dmg_sum_s   = {SUM_W{1'b0}};
        kill_type_s = {TYPE_W{1'b0}};
        front_s     = {POS_W{1'b1}};
        for (int i = 0; i < N_SLOTS; i++) begin
            dmg_sum_s   = dmg_sum_s + SUM_W'(atk_dmg_s[i]);
            kill_type_s = kill_type_s | (killed_s[i] ? type_s[i] : {TYPE_W{1'b0}});
            if (alive_nxt_s[i] && (pos_nxt_s[i] < front_s)) begin
                front_s = pos_nxt_s[i];
            end else begin
                front_s = front_s;
            end
        end
        if (dmg_sum_s > SUM_W'({DMG_W{1'b1}})) begin
            dmg_sat_s = {DMG_W{1'b1}};
        end else begin
            dmg_sat_s = dmg_sum_s[DMG_W-1:0];
        end
    end

    // Registered squad outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            spawn_ready_r  <= 1'b1;
            enemy_front_r  <= {POS_W{1'b1}};
            attack_valid_r <= 1'b0;
            damage_out_r   <= {DMG_W{1'b0}};
            kill_pulse_r   <= 1'b0;
            kill_type_r    <= {TYPE_W{1'b0}};
            alive_mask_r   <= {N_SLOTS{1'b0}};
        end else begin
            spawn_ready_r  <= |idle_nxt_s;
            enemy_front_r  <= front_s;
            attack_valid_r <= |attack_s;
            damage_out_r   <= dmg_sat_s;
            kill_pulse_r   <= |killed_s;
            kill_type_r    <= kill_type_s;
            alive_mask_r   <= alive_nxt_s;
        end
    end

    assign bus.spawn_ready  = spawn_ready_r;
    assign bus.enemy_front  = enemy_front_r;
    assign bus.attack_valid = attack_valid_r;
    assign bus.damage_out   = damage_out_r;
    assign bus.kill_pulse   = kill_pulse_r;
    assign bus.kill_type    = kill_type_r;
    assign bus.alive_mask   = alive_mask_r;

endmodule

// File: tb/tb_enemy_squad.sv
// Directed bench for enemy_squad: one default instance (DMG_W=8) and one
// narrow-damage instance (DMG_W=5) for the saturation case.
module tb_enemy_squad;
    import enemy_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    enemy_squad_if #(.N_SLOTS(4), .POS_W(9), .DMG_W(8)) bus_a ();
    enemy_squad_if #(.N_SLOTS(4), .POS_W(9), .DMG_W(5)) bus_b ();

    enemy_squad #(.N_SLOTS(4), .POS_W(9), .HP_W(8), .DMG_W(8),
                  .DEPLOY_CYCLES(3), .REGEN_PERIOD(8))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    enemy_squad #(.N_SLOTS(4), .POS_W(9), .HP_W(8), .DMG_W(5),
                  .DEPLOY_CYCLES(3), .REGEN_PERIOD(8))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic strike_a(input logic [7:0] amount);
        bus_a.damage_valid = 1'b1;
        bus_a.damage_in    = amount;
        cyc();
        bus_a.damage_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_a.spawn_valid = 1'b0; bus_a.spawn_type = 2'd0; bus_a.move_tick = 1'b0;
        bus_a.unit_front = 9'd0;  bus_a.damage_valid = 1'b0; bus_a.damage_in = 8'd0;
        bus_b.spawn_valid = 1'b0; bus_b.spawn_type = 2'd0; bus_b.move_tick = 1'b0;
        bus_b.unit_front = 9'd0;  bus_b.damage_valid = 1'b0; bus_b.damage_in = 5'd0;
        run(2);
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(bus_a.spawn_ready), 32'd1);
        check("rst_front", 32'(bus_a.enemy_front), 32'd511);
        check("rst_alive", 32'(bus_a.alive_mask), 32'd0);
        check("rst_atk", 32'(bus_a.attack_valid), 32'd0);
        check("rst_dmg", 32'(bus_a.damage_out), 32'd0);
        check("rst_kill", 32'(bus_a.kill_pulse), 32'd0);

        // 1: type 1 at front, ticking every cycle
        bus_a.unit_front = 9'd511; bus_a.move_tick = 1'b1;
        bus_a.spawn_valid = 1'b1; bus_a.spawn_type = 2'd1;
        cyc();
        bus_a.spawn_valid = 1'b0;
        check("t1_deploy0", 32'(bus_a.alive_mask), 32'd0);
        run(2);
        check("t1_deploy2", 32'(bus_a.alive_mask), 32'd0);
        cyc();
        check("t1_alive", 32'(bus_a.alive_mask), 32'd1);
        check("t1_front", 32'(bus_a.enemy_front), 32'd511);
        check("t1_noatk", 32'(bus_a.attack_valid), 32'd0);
        cyc();
        check("t1_atk", 32'(bus_a.attack_valid), 32'd1);
        check("t1_dmg", 32'(bus_a.damage_out), 32'd8);
        bus_a.move_tick = 1'b0;
        strike_a(8'd127);
        check("t1_atk_off", 32'(bus_a.attack_valid), 32'd0);
        check("t1_hp_left", 32'(bus_a.kill_pulse), 32'd0);
        strike_a(8'd1);
        check("t1_kill", 32'(bus_a.kill_pulse), 32'd1);
        check("t1_ktype", 32'(bus_a.kill_type), 32'd1);
        check("t1_gone", 32'(bus_a.alive_mask), 32'd0);
        check("t1_front_none", 32'(bus_a.enemy_front), 32'd511);
        strike_a(8'd5);
        check("t1_kill_once", 32'(bus_a.kill_pulse), 32'd0);

        // 2: speed-2 march, deploying slot untargetable, clamp then attack
        do_reset();
        bus_a.unit_front = 9'd100;
        bus_a.spawn_valid = 1'b1; bus_a.spawn_type = 2'd2;
        cyc();
        bus_a.spawn_valid = 1'b0;
        strike_a(8'd200);
        check("t2_deploy_safe", 32'(bus_a.kill_pulse), 32'd0);
        run(2);
        check("t2_alive", 32'(bus_a.alive_mask), 32'd1);
        bus_a.move_tick = 1'b1;
        run(5);
        bus_a.move_tick = 1'b0;
        check("t2_pos501", 32'(bus_a.enemy_front), 32'd501);
        bus_a.unit_front = 9'd500; bus_a.move_tick = 1'b1;
        cyc();
        check("t2_clamp", 32'(bus_a.enemy_front), 32'd500);
        check("t2_clamp_noatk", 32'(bus_a.attack_valid), 32'd0);
        cyc();
        check("t2_atk", 32'(bus_a.attack_valid), 32'd1);
        check("t2_dmg", 32'(bus_a.damage_out), 32'd2);
        bus_a.move_tick = 1'b0;

        // 3: fill all slots, 5th spawn refused, combined attack
        do_reset();
        bus_a.unit_front = 9'd511;
        for (int i = 0; i < 4; i++) begin
            bus_a.spawn_valid = 1'b1; bus_a.spawn_type = 2'(i);
            cyc();
        end
        check("t3_full", 32'(bus_a.spawn_ready), 32'd0);
        bus_a.spawn_type = 2'd0;
        cyc();
        bus_a.spawn_valid = 1'b0;
        run(2);
        check("t3_all_alive", 32'(bus_a.alive_mask), 32'd15);
        check("t3_still_full", 32'(bus_a.spawn_ready), 32'd0);
        bus_a.move_tick = 1'b1;
        cyc();
        bus_a.move_tick = 1'b0;
        check("t3_atk", 32'(bus_a.attack_valid), 32'd1);
        check("t3_dmg", 32'(bus_a.damage_out), 32'd30);

        // 4: strike hits the frontmost enemy only
        do_reset();
        bus_a.unit_front = 9'd200;
        bus_a.spawn_valid = 1'b1; bus_a.spawn_type = 2'd2;
        cyc();
        bus_a.spawn_valid = 1'b0; bus_a.move_tick = 1'b1;
        run(160);
        check("t4_park200", 32'(bus_a.enemy_front), 32'd200);
        bus_a.unit_front = 9'd300;
        bus_a.spawn_valid = 1'b1; bus_a.spawn_type = 2'd0;
        cyc();
        bus_a.spawn_valid = 1'b0;
        run(220);
        bus_a.move_tick = 1'b0;
        check("t4_two_alive", 32'(bus_a.alive_mask), 32'd3);
        check("t4_front200", 32'(bus_a.enemy_front), 32'd200);
        strike_a(8'd40);
        check("t4_kill", 32'(bus_a.kill_pulse), 32'd1);
        check("t4_ktype", 32'(bus_a.kill_type), 32'd2);
        check("t4_front300", 32'(bus_a.enemy_front), 32'd300);
        check("t4_mask", 32'(bus_a.alive_mask), 32'd2);
        strike_a(8'd63);
        check("t4_hp64_a", 32'(bus_a.kill_pulse), 32'd0);
        strike_a(8'd1);
        check("t4_hp64_b", 32'(bus_a.kill_pulse), 32'd1);
        check("t4_ktype0", 32'(bus_a.kill_type), 32'd0);
        check("t4_empty", 32'(bus_a.alive_mask), 32'd0);

        // 5: saturation on the 5-bit damage instance, then reset mid-march
        bus_b.unit_front = 9'd511;
        bus_b.spawn_valid = 1'b1; bus_b.spawn_type = 2'd3;
        run(2);
        bus_b.spawn_valid = 1'b0;
        run(3);
        check("t5_alive", 32'(bus_b.alive_mask), 32'd3);
        bus_b.move_tick = 1'b1;
        cyc();
        check("t5_atk", 32'(bus_b.attack_valid), 32'd1);
        check("t5_sat", 32'(bus_b.damage_out), 32'd31);
        bus_b.unit_front = 9'd0;
        run(4);
        check("t5_march", 32'(bus_b.enemy_front), 32'd507);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t5_rst_mask", 32'(bus_b.alive_mask), 32'd0);
        check("t5_rst_front", 32'(bus_b.enemy_front), 32'd511);
        check("t5_rst_ready", 32'(bus_b.spawn_ready), 32'd1);
        check("t5_rst_atk", 32'(bus_b.attack_valid), 32'd0);
        bus_b.move_tick = 1'b0;

`ifdef ENEMY_REGEN_EN
        // 6: regeneration, capped at the table HP
        do_reset();
        bus_a.unit_front = 9'd511;
        bus_a.spawn_valid = 1'b1; bus_a.spawn_type = 2'd0;
        cyc();
        bus_a.spawn_valid = 1'b0;
        run(3);
        strike_a(8'd10);
        bus_a.move_tick = 1'b1;
        run(16);
        bus_a.move_tick = 1'b0;
        strike_a(8'd55);
        check("t6_hp56_a", 32'(bus_a.kill_pulse), 32'd0);
        strike_a(8'd1);
        check("t6_hp56_b", 32'(bus_a.kill_pulse), 32'd1);
        bus_a.spawn_valid = 1'b1;
        cyc();
        bus_a.spawn_valid = 1'b0;
        run(3);
        bus_a.move_tick = 1'b1;
        run(16);
        bus_a.move_tick = 1'b0;
        strike_a(8'd63);
        check("t6_cap_a", 32'(bus_a.kill_pulse), 32'd0);
        strike_a(8'd1);
        check("t6_cap_b", 32'(bus_a.kill_pulse), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
